// File: rtl/serial_adder.sv
// +--------------------------------------------------------------------------+
// | serial_adder : bit-serial LSB-first adder built from two half-adder       |
// | stages and a registered carry, with start/busy/done handshake.            |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opb_q, acc_q, sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, cout_q;

   logic             w_accept, w_last;
   logic             w_p, w_g, w_s, w_k, w_carry_next;
   logic [WIDTH-1:0] w_acc_next;

   assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign w_last   = (cnt_q == CNT_W'(WIDTH - 1));

   // Two cascaded half adders form the per-bit full adder.
   assign w_p          = opa_q[0] ^ opb_q[0];
   assign w_g          = opa_q[0] & opb_q[0];
   assign w_s          = w_p ^ carry_q;
   assign w_k          = w_p & carry_q;
   assign w_carry_next = w_g | w_k;
   // Shift-based insert avoids an empty slice when WIDTH is 1.
   assign w_acc_next   = (acc_q >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_accept) state_d = S_SHIFT;
         S_SHIFT: if (w_last)   state_d = S_DONE;
         S_DONE:  state_d = w_accept ? S_SHIFT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_SHIFT);
      done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (w_accept) begin
         opa_q   <= a;
         opb_q   <= b;
         carry_q <= cin;
         cnt_q   <= '0;
      end else if (state_q == S_SHIFT) begin
         opa_q   <= opa_q >> 1;
         opb_q   <= opb_q >> 1;
         acc_q   <= w_acc_next;
         carry_q <= w_carry_next;
         cnt_q   <= cnt_q + CNT_W'(1);
         if (w_last) begin
            sum_q  <= w_acc_next;
            cout_q <= w_carry_next;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

`default_nettype wire
